// File: rtl/apb_mem_slave_if.sv
// APB3/APB4 bus bundle for apb_mem_slave. PSTRB exists only when APB_PSTRB_EN is defined.
interface apb_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
`ifdef APB_PSTRB_EN
  logic [DATA_W/8-1:0] PSTRB;
`endif
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_PSTRB_EN
    output PSTRB,
`endif
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_PSTRB_EN
    input  PSTRB,
`endif
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave.sv
// Parametrised APB memory slave with wait states and PSLVERR on misaligned/out-of-range access.
// Define APB_PSTRB_EN to enable APB4 byte-strobe writes through PSTRB.
module apb_mem_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_mem_slave_if.slave   bus
);
  localparam int NB    = DATA_W / 8;
  localparam int AL    = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_write;
  logic                r_err;
  logic                r_pready;
  logic                r_pslverr;
  logic [DATA_W-1:0]   r_prdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [ADDR_W-1:0]   w_word;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_rd_idx;
  logic                w_misaligned;
  logic                w_oor;
  logic                w_err;
  logic                w_setup;
  logic                w_active;
  logic                w_set_ready;
  logic                w_ld_err;
  logic                w_ld_write;
  logic                w_commit;
  logic [NB-1:0]       w_be;

  assign w_word = bus.PADDR >> AL;
  assign w_idx  = w_word[IDX_W-1:0];
  // DEPTH is a power of two, so any bit above the index field means out of range.
  assign w_oor  = |(w_word >> IDX_W);

  generate
    if (AL > 0) begin : g_align
      assign w_misaligned = |bus.PADDR[AL-1:0];
    end else begin : g_no_align
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign w_err    = w_misaligned | w_oor;
  assign w_setup  = bus.PSEL & ~bus.PENABLE;
  assign w_active = bus.PSEL & bus.PENABLE;

  // With zero wait states the response is prepared on the setup edge from the live bus.
  assign w_set_ready = (r_state == IDLE) ? (w_setup && (WAIT_CYCLES == 0))
                                         : (w_active && !r_pready && (r_cnt == 4'd1));
  assign w_ld_err    = (r_state == IDLE) ? w_err       : r_err;
  assign w_ld_write  = (r_state == IDLE) ? bus.PWRITE  : r_write;
  assign w_rd_idx    = (r_state == IDLE) ? w_idx       : r_idx;

  assign w_commit = (r_state == ACCESS) && w_active && r_pready && r_write && !r_err && !PRESET;

`ifdef APB_PSTRB_EN
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_be
      assign w_be[gi] = bus.PSTRB[gi];
    end
  endgenerate
`else
  assign w_be = '1;
`endif

  always_ff @(posedge PCLK) begin
    if (w_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) begin
          r_mem[r_idx][b*8 +: 8] <= bus.PWDATA[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      if (w_set_ready) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_ld_err;
        if (!w_ld_write) begin
          r_prdata <= w_ld_err ? '0 : r_mem[w_rd_idx];
        end
      end
      unique case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state <= ACCESS;
            r_idx   <= w_idx;
            r_write <= bus.PWRITE;
            r_err   <= w_err;
            r_cnt   <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (w_active) begin
            if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end
            if (r_pready) begin
              r_state   <= IDLE;
              r_pready  <= 1'b0;
              r_pslverr <= 1'b0;
            end
          end else begin
            // Master dropped PSEL/PENABLE early: abandon the transfer.
            r_state   <= IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.PRDATA  = r_prdata;
  assign bus.PREADY  = r_pready;
  assign bus.PSLVERR = r_pslverr;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (0 and 3 wait states) against a word-array reference model.
module tb_apb_mem_slave;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite = 1'b0;
  logic        penable = 1'b0;
  logic        psel [2];
`ifdef APB_PSTRB_EN
  logic [3:0]  pstrb = 4'hF;
`endif

  always #5 clk = ~clk;

  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  assign bus0.PSEL    = psel[0];
  assign bus0.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;
  assign bus1.PSEL    = psel[1];
  assign bus1.PENABLE = penable;
  assign bus1.PWRITE  = pwrite;
  assign bus1.PADDR   = paddr;
  assign bus1.PWDATA  = pwdata;
`ifdef APB_PSTRB_EN
  assign bus0.PSTRB   = pstrb;
  assign bus1.PSTRB   = pstrb;
`endif

  apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus0.slave)
  );

  apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus1.slave)
  );

  logic        obs_ready [2];
  logic        obs_err   [2];
  logic [31:0] obs_rdata [2];
  assign obs_ready[0] = bus0.PREADY;
  assign obs_err[0]   = bus0.PSLVERR;
  assign obs_rdata[0] = bus0.PRDATA;
  assign obs_ready[1] = bus1.PREADY;
  assign obs_err[1]   = bus1.PSLVERR;
  assign obs_rdata[1] = bus1.PRDATA;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic        exp_ready [2];
  logic        exp_err   [2];
  logic [31:0] exp_rdata [2];
  logic [31:0] mdl [2][DEPTH];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t", name, k, act, req, $time);
    end
  endtask

  // Every cycle, all registered outputs of both instances must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("PREADY", k, {31'b0, obs_ready[k]}, {31'b0, exp_ready[k]});
        check("PSLVERR", k, {31'b0, obs_err[k]}, {31'b0, exp_err[k]});
        check("PRDATA", k, obs_rdata[k], exp_rdata[k]);
      end
    end
  end

  function automatic bit mdl_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  task automatic mdl_write(input int k, input logic [9:0] idx, input logic [31:0] d, input logic [3:0] s);
    logic [3:0] eff;
`ifdef APB_PSTRB_EN
    eff = s;
`else
    eff = 4'hF;
`endif
    for (int b = 0; b < 4; b++) begin
      if (eff[b]) mdl[k][idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  // One APB transfer on instance k; abort_at >= 0 drops PSEL in that access cycle.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int abort_at,
                      output logic [31:0] rd, output logic er, output int lat);
    int         w;
    bit         e;
    bit         done;
    logic       rdy;
    logic [9:0] idx;
    w   = (k == 1) ? 3 : 0;
    e   = mdl_err(a);
    idx = a[11:2];
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
`ifdef APB_PSTRB_EN
    pstrb   = s;
`endif
    exp_ready[k] = 1'b0;
    exp_err[k]   = 1'b0;
    lat  = 1;
    done = 1'b0;
    rd   = '0;
    er   = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 16 && !done; i++) begin
      if (i == abort_at) psel[k] = 1'b0;
      exp_ready[k] = (i == w);
      exp_err[k]   = (i == w) && e;
      if (i == w && !wr) exp_rdata[k] = e ? 32'h0 : mdl[k][idx];
      lat++;
      @(negedge clk);
      rdy = obs_ready[k];
      rd  = obs_rdata[k];
      er  = obs_err[k];
      @(posedge clk); #1;
      if (i == abort_at) begin
        done = 1'b1;
      end else if (rdy === 1'b1) begin
        done = 1'b1;
        if (wr && !e) mdl_write(k, idx, d, s);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout dut%0d addr=%h got=no PREADY want=PREADY within %0d cycles", k, a, w + 1);
    end
    psel[k] = 1'b0;
    penable = 1'b0;
    exp_ready[k] = 1'b0;
    exp_err[k]   = 1'b0;
    $display("xfer dut%0d %s addr=%h wdata=%h strb=%h rdata=%h err=%0d lat=%0d%s",
             k, wr ? "WR" : "RD", a, d, s, rd, er, lat, (abort_at >= 0) ? " aborted" : "");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] saved;
    logic [3:0]  s;
    bit          wr;
    int          k;
    int          r;

    psel[0] = 1'b0;
    psel[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_ready[i] = 1'b0;
      exp_err[i]   = 1'b0;
      exp_rdata[i] = '0;
    end

    // Reset held for three edges; outputs must read zero from the first edge on.
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // Give every word the random tests touch a known value.
    for (int kk = 0; kk < 2; kk++) begin
      for (int j = 0; j < 64; j++) begin
        xfer(kk, 1'b1, 32'(j * 4), $urandom, 4'hF, -1, rd, er, lat);
      end
    end

    // Zero-wait write then read.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, -1, rd, er, lat);
    check("wr_latency", 0, 32'(lat), 32'd2);
    check("wr_slverr", 0, {31'b0, er}, 32'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, -1, rd, er, lat);
    check("rd_data", 0, rd, 32'hDEADBEEF);
    check("rd_latency", 0, 32'(lat), 32'd2);
    check("rd_slverr", 0, {31'b0, er}, 32'd0);

    // Three wait states: latency 5, then aborted write leaves memory alone.
    xfer(1, 1'b1, 32'h0, 32'hA5A50001, 4'hF, -1, rd, er, lat);
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, -1, rd, er, lat);
    check("ws_rd_data", 1, rd, 32'hA5A50001);
    check("ws_latency", 1, 32'(lat), 32'd5);
    xfer(1, 1'b1, 32'h4, 32'h0F0F0F0F, 4'hF, -1, rd, er, lat);
    xfer(1, 1'b1, 32'h4, 32'h5555AAAA, 4'hF, 2, rd, er, lat);
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, 2, rd, er, lat);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, -1, rd, er, lat);
    check("abort_no_write", 1, rd, 32'h0F0F0F0F);

    // Out-of-range write is dropped; misaligned read returns error and zero.
    xfer(0, 1'b1, 32'h0, 32'h11223344, 4'hF, -1, rd, er, lat);
    xfer(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, -1, rd, er, lat);
    check("oor_wr_slverr", 0, {31'b0, er}, 32'd1);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, -1, rd, er, lat);
    check("oor_mem_intact", 0, rd, 32'h11223344);
    xfer(0, 1'b0, 32'h2, 32'h0, 4'hF, -1, rd, er, lat);
    check("mis_rd_slverr", 0, {31'b0, er}, 32'd1);
    check("mis_rd_data", 0, rd, 32'h0);
    xfer(1, 1'b0, 32'h1000, 32'h0, 4'hF, -1, rd, er, lat);
    check("oor_rd_slverr_ws", 1, {31'b0, er}, 32'd1);

    // PSEL+PENABLE straight from IDLE is ignored.
    psel[0] = 1'b1;
    penable = 1'b1;
    paddr   = 32'h10;
    pwrite  = 1'b1;
    pwdata  = 32'h0BAD0BAD;
    @(posedge clk); #1;
    psel[0] = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, -1, rd, er, lat);
    check("viol_ignored", 0, rd, 32'hDEADBEEF);

`ifdef APB_PSTRB_EN
    xfer(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, -1, rd, er, lat);
    xfer(0, 1'b1, 32'h8, 32'h12345678, 4'b0101, -1, rd, er, lat);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, -1, rd, er, lat);
    check("strb_merge", 0, rd, 32'hFF34FF78);
    xfer(0, 1'b1, 32'h8, 32'h00000000, 4'h0, -1, rd, er, lat);
    check("strb0_slverr", 0, {31'b0, er}, 32'd0);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, -1, rd, er, lat);
    check("strb0_no_write", 0, rd, 32'hFF34FF78);
`endif

    // Reset asserted on the completing edge of a write: nothing is committed.
    saved = mdl[0][8];
    psel[0] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h20;
    pwdata  = 32'hDEADDEAD;
`ifdef APB_PSTRB_EN
    pstrb   = 4'hF;
`endif
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    exp_ready[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      exp_ready[i] = 1'b0;
      exp_err[i]   = 1'b0;
      exp_rdata[i] = '0;
    end
    psel[0] = 1'b0;
    penable = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, -1, rd, er, lat);
    check("rst_no_commit", 0, rd, saved);

    // Back-to-back write/read pairs, no idle cycles.
    for (int kk = 0; kk < 2; kk++) begin
      for (int j = 0; j < 16; j++) begin
        d = $urandom;
        xfer(kk, 1'b1, 32'(j * 4), d, 4'hF, -1, rd, er, lat);
        check("b2b_wr_slverr", kk, {31'b0, er}, 32'd0);
        xfer(kk, 1'b0, 32'(j * 4), 32'h0, 4'hF, -1, rd, er, lat);
        check("b2b_rd_data", kk, rd, d);
        check("b2b_rd_slverr", kk, {31'b0, er}, 32'd0);
      end
    end

    // Random mix of reads, writes, error addresses and idle gaps.
    for (int n = 0; n < 200; n++) begin
      k  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      a  = 32'($urandom_range(0, 63)) << 2;
      if (r == 7) a = a | 32'($urandom_range(1, 3));
      else if (r >= 8) a = $urandom | 32'h1000;
`ifdef APB_PSTRB_EN
      s = 4'($urandom_range(0, 15));
`else
      s = 4'hF;
`endif
      xfer(k, wr, a, $urandom, s, -1, rd, er, lat);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk);
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB3/APB4 memory-mapped slave that replaces the fixed 32-bit, 1024-word, zero-wait APB slave. It adds configurable data/address width, memory depth and wait states, plus a `PSLVERR` response for out-of-range and misaligned accesses. Optional APB4 byte strobes are selected at compile time. It sits behind the APB bridge as a generic register/scratch RAM target and uses one clock domain.

## Interface
- `ADDR_W`, 32, width of `PADDR` (byte address).
- `DATA_W`, 32, width of `PWDATA`/`PRDATA`; one of 8, 16, 32, 64.
- `DEPTH`, 1024, number of `DATA_W` words; a power of two, 2..65536.
- `WAIT_CYCLES`, 0, wait states inserted per transfer; 0..15.
- `PCLK`  in  1  clock; all state changes on the rising edge.
- `PRESET`  in  1  synchronous reset, active-high.
- `PSEL`  in  1  slave select.
- `PENABLE`  in  1  access-phase indicator.
- `PWRITE`  in  1  1 = write, 0 = read.
- `PADDR`  in  `ADDR_W`  byte address.
- `PWDATA`  in  `DATA_W`  write data.
- `PSTRB`  in  `DATA_W/8`  byte write strobes; present only with `APB_PSTRB_EN`.
- `PRDATA`  out  `DATA_W`  read data; registered.
- `PREADY`  out  1  transfer-complete; registered.
- `PSLVERR`  out  1  error response, valid only when `PREADY=1`; registered.

## Operation
- `AL = log2(DATA_W/8)` and `IDX = PADDR >> AL`.
- An access is misaligned when `PADDR[AL-1:0] != 0`. For `DATA_W=8` no access is misaligned.
- An access is out of range when `IDX >= DEPTH`.
- An errored access is one that is misaligned or out of range.
- The state machine has two states, `IDLE` and `ACCESS`.
  - `IDLE` → `ACCESS` on `PSEL=1`, `PENABLE=0`. On that edge the block latches the address, `PWRITE` and error flags, and loads the counter `cnt` with `WAIT_CYCLES`.
  - `IDLE` with `PSEL=1`, `PENABLE=1` is a protocol violation: the block ignores it and stays in `IDLE`.
  - In `ACCESS` with `PSEL=1`, `PENABLE=1`:
    - if `cnt != 0`, decrement `cnt`;
    - if `PREADY=1`, the transfer completes on this edge and the FSM returns to `IDLE`.
  - In `ACCESS`, if `PSEL=0` or `PENABLE=0` before completion, the transfer is aborted: return to `IDLE`, no write, `PREADY` and `PSLVERR` go to 0.
- `PREADY` is driven 1 during the final `ACCESS` cycle and 0 otherwise. It is set on the edge where `cnt` reaches 0, or on the setup edge when `WAIT_CYCLES=0`.
- `PSLVERR` is set together with `PREADY` when the latched access is errored. It clears with `PREADY`.
- Writes:
  - commit on the completing edge, using the `PWDATA`/`PSTRB` sampled on that edge;
  - errored writes are dropped and memory is unchanged.
- Reads:
  - `PRDATA` is loaded with `mem[IDX]` on the same edge that sets `PREADY`;
  - errored reads load `PRDATA` with 0;
  - `PRDATA` holds its value between transfers and is not updated by writes.
- Reset: `PREADY=0`, `PSLVERR=0`, `PRDATA=0`, state `IDLE`, `cnt=0`. Memory contents are not reset.
- Reset mid-transfer aborts the transfer. A write whose completing edge coincides with `PRESET=1` is not committed.

## Timing
- Read/write latency is `2 + WAIT_CYCLES` cycles, counted from the first setup-phase cycle to the completing edge inclusive.
- With `WAIT_CYCLES=0`: setup cycle, then access cycle with `PREADY=1`.
- Back-to-back transfers:
  - a new setup phase may follow a completed transfer on the very next cycle;
  - throughput is one transfer per `2 + WAIT_CYCLES` cycles;
  - no idle cycle is required.
- `PADDR`, `PWRITE` and `PSEL` are sampled only on the setup edge. Changes during `ACCESS` do not affect the transfer, except that `PSEL=0` aborts it.
- Read-after-write to the same address in consecutive transfers returns the new data.

## Configuration
- `APB_PSTRB_EN` defined:
  - the `PSTRB` port exists;
  - on a write, byte lane `i` of `mem[IDX]` is updated only if `PSTRB[i]=1`;
  - `PSTRB` is ignored on reads;
  - a write with `PSTRB=0` completes with `PSLVERR=0` and does not modify memory.
- `APB_PSTRB_EN` undefined: the `PSTRB` port is absent and every write updates the full word.

## Test plan
- Reset: `PRESET=1` for 3 cycles → `PREADY=0`, `PSLVERR=0`, `PRDATA=0`, no write accepted while reset is held.
- `WAIT_CYCLES=0`, `DATA_W=32`: write `0xDEADBEEF` to `0x10`, then read `0x10` → `PREADY` high in each access cycle, `PRDATA=0xDEADBEEF`, 4 cycles total, `PSLVERR=0`.
- `WAIT_CYCLES=3`: read `0x0` → `PREADY` low for 3 access cycles then high for one, latency 5 cycles; `PSEL` dropped after 2 access cycles → abort, `PREADY` stays 0.
- `DEPTH=1024`, `DATA_W=32`:
  - write `0x1000` (`IDX=1024`) → `PSLVERR=1` with `PREADY`, memory unchanged;
  - read `0x0002` (misaligned) → `PSLVERR=1`, `PRDATA=0`.
- `APB_PSTRB_EN`: write `0xFFFFFFFF`, then write `0x12345678` with `PSTRB=4'b0101`, read back → `0xFF34FF78`.
- Back-to-back: 16 alternating write/read pairs to addresses `0x0..0x3C` with random data and no idle cycles → every read matches the preceding write, no `PSLVERR`.
